coherent_mem_ctrl: RTL and testbench

//  Shared single-port memory controller for NUM_PROCS processors. Round-robin arbitration, fixed access latency,
//  per-line MSI-lite state (I/S/M + owner ID). Sits between processor request ports and on-chip storage.

---
 rtl/coherent_mem_ctrl_pkg.sv | 61 ++++++
 rtl/coherent_mem_ctrl_if.sv | 26 ++
 rtl/coherent_mem_ctrl_rr_arbiter.sv | 46 ++++
 rtl/coherent_mem_ctrl.sv | 177 +++++++++++++++++
 tb/tb_coherent_mem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/coherent_mem_ctrl_pkg.sv
// Shared types for the coherent memory controller: line states, ops, control states
// and the MSI-lite transition rule applied when an access completes.
package coherent_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        COH_I = 2'b00,
        COH_M = 2'b01,
        COH_S = 2'b10
    } coh_state_t;

    typedef enum logic [1:0] {
        OP_READ    = 2'b00,
        OP_WRITE   = 2'b01,
        OP_RELEASE = 2'b10,
        OP_RSVD    = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } ctrl_state_t;

    typedef struct packed {
        logic       err;
        logic       wr_data;
        logic       take_own;
        coh_state_t nxt;
    } coh_result_t;

    // A line held Modified by another processor refuses every op except none.
    function automatic coh_result_t coh_apply(op_t op, coh_state_t cur, logic is_owner);
        coh_result_t r;
        logic        foreign;
        foreign = (cur == COH_M) && !is_owner;
        r = '{err: 1'b0, wr_data: 1'b0, take_own: 1'b0, nxt: cur};
        case (op)
            OP_READ: begin
                if (foreign) r.err = 1'b1;
                else if (cur == COH_I) r.nxt = COH_S;
            end
            OP_WRITE: begin
                if (foreign) begin
                    r.err = 1'b1;
                end else begin
                    r.wr_data  = 1'b1;
                    r.take_own = 1'b1;
                    r.nxt      = COH_M;
                end
            end
            OP_RELEASE: begin
                if (cur == COH_M && is_owner) r.nxt = COH_S;
                else r.err = 1'b1;
            end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/coherent_mem_ctrl_if.sv
// Processor-side request/response bus of the coherent memory controller.
interface coherent_mem_ctrl_if #(
    parameter int unsigned NUM_PROCS = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 13
);
    logic [NUM_PROCS-1:0]        proc_req;
    logic [2*NUM_PROCS-1:0]      proc_op;
    logic [ADDR_W*NUM_PROCS-1:0] proc_addr;
    logic [DATA_W*NUM_PROCS-1:0] proc_wdata;
    logic [NUM_PROCS-1:0]        proc_gnt;
    logic [NUM_PROCS-1:0]        proc_resp;
    logic                        resp_err;
    logic [DATA_W-1:0]           rdata;
    logic                        ready;

    modport master (
        output proc_req, proc_op, proc_addr, proc_wdata,
        input  proc_gnt, proc_resp, resp_err, rdata, ready
    );

    modport slave (
        input  proc_req, proc_op, proc_addr, proc_wdata,
        output proc_gnt, proc_resp, resp_err, rdata, ready
    );
endinterface

// File: rtl/coherent_mem_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the pointer, and moves
// the pointer past the winner when the grant is taken.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_id
);
    localparam int unsigned IDW = $clog2(N);

    logic [IDW-1:0] ptr_q, ptr_d;
    logic           found;

    always_comb begin
        int unsigned idx;
        idx        = 0;
        found      = 1'b0;
        gnt_onehot = '0;
        gnt_id     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_q) + k) % N;
            if (!found && req[IDW'(idx)]) begin
                found                   = 1'b1;
                gnt_id                  = IDW'(idx);
                gnt_onehot[IDW'(idx)]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gnt_id == IDW'(N - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

endmodule

// File: rtl/coherent_mem_ctrl.sv
// Shared single-port memory controller with round-robin arbitration, fixed latency
// and per-line MSI-lite state; outputs are registered one cycle after each decision.
module coherent_mem_ctrl
    import coherent_mem_ctrl_pkg::*;
#(
    parameter int unsigned NUM_PROCS = 4,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned ADDR_W    = 13,
    parameter int unsigned LATENCY   = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    coherent_mem_ctrl_if.slave bus
);
    localparam int unsigned ID_W      = $clog2(NUM_PROCS);
    localparam int unsigned DEPTH     = 2 ** ADDR_W;
    localparam int unsigned CNT_W     = $clog2(LATENCY + 1);
    localparam int unsigned BUSY_LAST = (LATENCY >= 2) ? LATENCY - 2 : 0;

    ctrl_state_t          st_q, st_d;
    logic [ADDR_W-1:0]    init_idx_q, init_idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    op_t                  lat_op_q, lat_op_d;
    logic [ADDR_W-1:0]    lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0]    lat_wdata_q, lat_wdata_d;
    logic [ID_W-1:0]      lat_id_q, lat_id_d;
    logic [NUM_PROCS-1:0] gnt_q, gnt_d;
    logic [NUM_PROCS-1:0] resp_q, resp_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic                 ready_q, ready_d;

    logic [NUM_PROCS-1:0] arb_gnt;
    logic [ID_W-1:0]      arb_id;
    logic                 advance;

    logic [DATA_W-1:0]    data_mem  [DEPTH];
    coh_state_t           state_mem [DEPTH];
    logic [ID_W-1:0]      owner_mem [DEPTH];

    logic                 meta_we, data_we;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    coh_state_t           wr_state;
    logic [ID_W-1:0]      wr_owner;
    logic [DATA_W-1:0]    rd_data;
    coh_state_t           rd_state;
    logic [ID_W-1:0]      rd_owner;
    coh_result_t          res;

    rr_arbiter #(.N(NUM_PROCS)) u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (bus.proc_req),
        .advance    (advance),
        .gnt_onehot (arb_gnt),
        .gnt_id     (arb_id)
    );

    assign rd_data  = data_mem[lat_addr_q];
    assign rd_state = state_mem[lat_addr_q];
    assign rd_owner = owner_mem[lat_addr_q];
    assign res      = coh_apply(lat_op_q, rd_state, rd_owner == lat_id_q);

    always_comb begin
        st_d        = st_q;
        init_idx_d  = init_idx_q;
        cnt_d       = cnt_q;
        lat_op_d    = lat_op_q;
        lat_addr_d  = lat_addr_q;
        lat_wdata_d = lat_wdata_q;
        lat_id_d    = lat_id_q;
        ready_d     = ready_q;
        gnt_d       = '0;
        resp_d      = '0;
        err_d       = 1'b0;
        rdata_d     = '0;
        advance     = 1'b0;
        meta_we     = 1'b0;
        data_we     = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        wr_state    = COH_I;
        wr_owner    = '0;
        case (st_q)
            ST_INIT: begin
                meta_we    = 1'b1;
                data_we    = 1'b1;
                wr_addr    = init_idx_q;
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) begin
                    st_d    = ST_IDLE;
                    ready_d = 1'b1;
                end
            end
            ST_IDLE: begin
                if (|bus.proc_req) begin
                    advance  = 1'b1;
                    gnt_d    = arb_gnt;
                    lat_id_d = arb_id;
                    for (int unsigned p = 0; p < NUM_PROCS; p++) begin
                        if (arb_gnt[p]) begin
                            lat_op_d    = op_t'(bus.proc_op[p*2 +: 2]);
                            lat_addr_d  = bus.proc_addr[p*ADDR_W +: ADDR_W];
                            lat_wdata_d = bus.proc_wdata[p*DATA_W +: DATA_W];
                        end
                    end
                    cnt_d = '0;
                    st_d  = (LATENCY == 1) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(BUSY_LAST)) st_d = ST_RESP;
                else cnt_d = cnt_q + 1'b1;
            end
            ST_RESP: begin
                // Metadata is rewritten every completion; refused ops write back the old values.
                meta_we          = 1'b1;
                wr_addr          = lat_addr_q;
                wr_state         = res.nxt;
                wr_owner         = res.take_own ? lat_id_q : rd_owner;
                data_we          = res.wr_data;
                wr_data          = lat_wdata_q;
                resp_d[lat_id_q] = 1'b1;
                err_d            = res.err;
                rdata_d          = (lat_op_q == OP_READ && !res.err) ? rd_data : '0;
                st_d             = ST_IDLE;
            end
            default: st_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q        <= ST_INIT;
            init_idx_q  <= '0;
            cnt_q       <= '0;
            lat_op_q    <= OP_READ;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_id_q    <= '0;
            gnt_q       <= '0;
            resp_q      <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            ready_q     <= 1'b0;
        end else begin
            st_q        <= st_d;
            init_idx_q  <= init_idx_d;
            cnt_q       <= cnt_d;
            lat_op_q    <= lat_op_d;
            lat_addr_q  <= lat_addr_d;
            lat_wdata_q <= lat_wdata_d;
            lat_id_q    <= lat_id_d;
            gnt_q       <= gnt_d;
            resp_q      <= resp_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (meta_we) begin
            state_mem[wr_addr] <= wr_state;
            owner_mem[wr_addr] <= wr_owner;
        end
        if (data_we) data_mem[wr_addr] <= wr_data;
    end

    assign bus.proc_gnt  = gnt_q;
    assign bus.proc_resp = resp_q;
    assign bus.resp_err  = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.ready     = ready_q;

endmodule

// File: tb/tb_coherent_mem_ctrl.sv
// Directed bench for coherent_mem_ctrl with a cycle-level reference model and per-cycle output compare.
module tb_coherent_mem_ctrl;
    localparam int NP    = 4;
    localparam int DW    = 16;
    localparam int AW    = 13;
    localparam int LAT   = 10;
    localparam int DEPTH = 1 << AW;
    localparam int MI = 0, MM = 1, MS = 2;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    coherent_mem_ctrl_if #(.NUM_PROCS(NP), .DATA_W(DW), .ADDR_W(AW)) bus ();

    coherent_mem_ctrl #(.NUM_PROCS(NP), .DATA_W(DW), .ADDR_W(AW), .LATENCY(LAT)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int total = 0;
    int bad   = 0;
    int resp_cnt = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: line contents and states, arbitration pointer, in-flight access.
    logic [DW-1:0] m_data [DEPTH];
    int            m_st   [DEPTH];
    int            m_own  [DEPTH];
    int            init_left = DEPTH, busy_left = 0, m_ptr = 0;
    bit            m_ready = 0, m_busy = 0;
    int            p_id = 0, p_op = 0, p_addr = 0;
    logic [DW-1:0] p_wd = '0;
    logic [NP-1:0] e_gnt = '0, e_resp = '0;
    logic          e_err = 1'b0, e_ready = 1'b0;
    logic [DW-1:0] e_rdata = '0;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = '0;
            m_st[i]   = MI;
            m_own[i]  = 0;
        end
        init_left = DEPTH;
        m_ready = 0; m_busy = 0; m_ptr = 0;
        e_gnt = '0; e_resp = '0; e_err = 1'b0; e_rdata = '0; e_ready = 1'b0;
    endtask

    task automatic complete();
        bit own;
        int st;
        own = (m_own[p_addr] == p_id);
        st  = m_st[p_addr];
        e_resp[p_id] = 1'b1;
        case (p_op)
            0: if (st == MM && !own) e_err = 1'b1;
               else begin
                   e_rdata = m_data[p_addr];
                   if (st == MI) m_st[p_addr] = MS;
               end
            1: if (st == MM && !own) e_err = 1'b1;
               else begin
                   m_data[p_addr] = p_wd;
                   m_st[p_addr]   = MM;
                   m_own[p_addr]  = p_id;
               end
            2: if (st == MM && own) m_st[p_addr] = MS;
               else e_err = 1'b1;
            default: e_err = 1'b1;
        endcase
    endtask

    task automatic model_step();
        e_gnt = '0; e_resp = '0; e_err = 1'b0; e_rdata = '0;
        if (!m_ready) begin
            init_left--;
            if (init_left == 0) m_ready = 1;
            e_ready = m_ready;
        end else if (m_busy) begin
            busy_left--;
            if (busy_left == 0) begin
                m_busy = 0;
                complete();
            end
        end else if (bus.proc_req != '0) begin
            for (int k = 0; k < NP; k++) begin
                int c;
                c = (m_ptr + k) % NP;
                if (bus.proc_req[c]) begin
                    p_id = c;
                    break;
                end
            end
            e_gnt[p_id] = 1'b1;
            p_op   = int'(bus.proc_op[p_id*2 +: 2]);
            p_addr = int'(bus.proc_addr[p_id*AW +: AW]);
            p_wd   = bus.proc_wdata[p_id*DW +: DW];
            m_ptr  = (p_id + 1) % NP;
            m_busy = 1;
            busy_left = LAT;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        chk("gnt", bus.proc_gnt, e_gnt);
        chk("resp", bus.proc_resp, e_resp);
        chk("resp_err", bus.resp_err, e_err);
        chk("rdata", bus.rdata, e_rdata);
        chk("ready", bus.ready, e_ready);
        if (bus.proc_resp != '0) resp_cnt++;
    end

    // Driver helpers; results of the last run are captured per processor.
    int            order[$];
    int            lat_r [NP];
    logic          err_r [NP];
    logic [DW-1:0] rd_r  [NP];

    task automatic setp(int p, int op, int addr, int wd);
        bus.proc_op[p*2 +: 2]     = 2'(op);
        bus.proc_addr[p*AW +: AW] = AW'(addr);
        bus.proc_wdata[p*DW +: DW] = DW'(wd);
    endtask

    task automatic run(logic [NP-1:0] mask);
        logic [NP-1:0] pg, pr;
        int gt [NP];
        int cyc;
        pg = mask; pr = mask; cyc = 0;
        for (int p = 0; p < NP; p++) gt[p] = 0;
        order.delete();
        @(negedge clk);
        bus.proc_req = bus.proc_req | mask;
        while (pr != '0 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            for (int p = 0; p < NP; p++) begin
                if (pg[p] && bus.proc_gnt[p]) begin
                    pg[p] = 1'b0;
                    bus.proc_req[p] = 1'b0;
                    gt[p] = cyc;
                    order.push_back(p);
                end else if (pr[p] && !pg[p] && bus.proc_resp[p]) begin
                    pr[p]    = 1'b0;
                    lat_r[p] = cyc - gt[p];
                    err_r[p] = bus.resp_err;
                    rd_r[p]  = bus.rdata;
                end
            end
        end
        chk("run_done", 32'(pr), 0);
    endtask

    task automatic one(int p, int op, int addr, int wd);
        setp(p, op, addr, wd);
        run(NP'(1 << p));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.ready && n < 2 * DEPTH);
        chk("init_cycles", n, DEPTH);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int w, rc0;
        bus.proc_req = '0; bus.proc_op = '0; bus.proc_addr = '0; bus.proc_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        wait_ready();

        // Initial read of a fresh line
        one(0, 0, 'h10, 0);
        chk("t1_lat", lat_r[0], LAT);
        chk("t1_err", err_r[0], 0);
        chk("t1_rdata", rd_r[0], 0);
        chk("t1_line_S", m_st['h10], MS);

        // Write then reads by owner and by another processor
        one(1, 1, 'h100, 'hBEEF);
        chk("t2_wr_lat", lat_r[1], LAT);
        chk("t2_wr_err", err_r[1], 0);
        one(1, 0, 'h100, 0);
        chk("t2_rd_own", rd_r[1], 'hBEEF);
        chk("t2_rd_own_err", err_r[1], 0);
        one(2, 0, 'h100, 0);
        chk("t2_rd_foreign_err", err_r[2], 1);
        chk("t2_rd_foreign_data", rd_r[2], 0);
        one(3, 0, 'h20, 0);
        chk("t2_p3_err", err_r[3], 0);

        // All four at once with pointer back at 0
        setp(0, 0, 'h30, 0);
        setp(1, 0, 'h100, 0);
        setp(2, 1, 'h40, 'h1234);
        setp(3, 0, 'h40, 0);
        run(4'hF);
        chk("t3_ngrants", order.size(), 4);
        for (int i = 0; i < NP; i++) begin
            chk("t3_order", (order.size() > i) ? order[i] : -1, i);
            chk("t3_lat", lat_r[i], LAT);
        end
        chk("t3_p1_data", rd_r[1], 'hBEEF);
        chk("t3_p1_err", err_r[1], 0);
        chk("t3_p3_err", err_r[3], 1);
        chk("t3_p3_data", rd_r[3], 0);

        // Release by owner, shared read, refused release
        one(1, 2, 'h100, 0);
        chk("t4_rel_err", err_r[1], 0);
        chk("t4_line_S", m_st['h100], MS);
        one(2, 0, 'h100, 0);
        chk("t4_p2_data", rd_r[2], 'hBEEF);
        chk("t4_p2_err", err_r[2], 0);
        one(0, 2, 'h100, 0);
        chk("t4_bad_rel_err", err_r[0], 1);

        // Reserved op and write over a shared line
        one(3, 3, 'h100, 'hFFFF);
        chk("t6_rsvd_err", err_r[3], 1);
        chk("t6_rsvd_lat", lat_r[3], LAT);
        one(2, 0, 'h100, 0);
        chk("t6_unchanged", rd_r[2], 'hBEEF);
        one(0, 1, 'h100, 'h5555);
        chk("t6_wr_err", err_r[0], 0);
        chk("t6_line_M", m_st['h100], MM);
        chk("t6_owner", m_own['h100], 0);
        one(2, 0, 'h100, 0);
        chk("t6_p2_refused", err_r[2], 1);
        one(0, 0, 'h100, 0);
        chk("t6_p0_data", rd_r[0], 'h5555);

        // Reset in the middle of an access
        one(1, 1, 'h200, 'hA5A5);
        one(1, 0, 'h200, 0);
        chk("t5_pre_data", rd_r[1], 'hA5A5);
        setp(0, 0, 'h200, 0);
        @(negedge clk);
        bus.proc_req[0] = 1'b1;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus.proc_gnt[0] && w < 50);
        chk("t5_gnt", bus.proc_gnt[0], 1);
        bus.proc_req[0] = 1'b0;
        rc0 = resp_cnt;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        wait_ready();
        chk("t5_no_resp", resp_cnt - rc0, 0);
        one(0, 0, 'h200, 0);
        chk("t5_cleared", rd_r[0], 0);
        chk("t5_cleared_err", err_r[0], 0);
        one(1, 0, 'h100, 0);
        chk("t5_cleared2", rd_r[1], 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
